// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider; clock and reset stay outside.
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring integer divider: one quotient bit per clock, sign fix-up in a final state.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd, r_dsr, r_orig, r_quot, r_remn;
  logic             r_neg_q, r_neg_r, r_zero, r_div_zero, r_done;
  logic             w_busy, w_last, w_sa, w_sb, w_qbit;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_sa    = bus.signed_op & bus.dividend[WIDTH-1];
  assign w_sb    = bus.signed_op & bus.divisor[WIDTH-1];
  assign w_mag_a = w_sa ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_mag_b = w_sb ? (~bus.divisor + 1'b1) : bus.divisor;
  assign w_last  = (r_count == CW'(WIDTH - 1));

  // r_dvd doubles as the quotient: dividend bits leave at the MSB, quotient bits enter at the LSB.
  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = (bus.divisor == '0) ? FIX : CALC;
      CALC: begin
        w_busy = 1'b1;
        if (w_last) w_next = FIX;
      end
      FIX: begin
        w_busy = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_orig     <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_quot     <= '0;
      r_remn     <= '0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_orig  <= bus.dividend;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_zero  <= (bus.divisor == '0);
          r_dvd   <= w_mag_a;
          r_dsr   <= w_mag_b;
          r_rem   <= '0;
          r_count <= '0;
        end
        CALC: begin
          r_rem   <= w_qbit ? w_diff : w_shift;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          if (r_zero) begin
            r_quot <= '1;
            r_remn <= r_orig;
          end else begin
            r_quot <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
            r_remn <= r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
          end
          r_div_zero <= r_zero;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remn;
  assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=32; outputs sampled on the falling edge.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  seq_divider_if #(.WIDTH(32)) bus();

  seq_divider #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // Drives one op; lat = edges after the accepting edge until done is seen, bcnt = busy samples.
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = sop; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.quotient !== 32'h0) begin errors++; $display("FAIL reset_quot: got %h expected 0", bus.quotient); end
    checks++; if (bus.remainder !== 32'h0) begin errors++; $display("FAIL reset_rem: got %h expected 0", bus.remainder); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.div_zero); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat, bcnt;
    repeat (3) @(negedge clk);
    run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL u_latency: got %0d expected 33", lat); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL u_busy_cycles: got %0d expected 33", bcnt); end
    checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL u_quot: got %h expected %h", bus.quotient, 32'd14); end
    checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL u_rem: got %h expected %h", bus.remainder, 32'd2); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL u_dz: got %b expected 0", bus.div_zero); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL u_done_pulse: got %b expected 0", bus.done); end
    repeat (10) @(negedge clk);
    checks++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++; $display("FAIL u_hold: got %h/%h expected 0000000e/00000002", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_signed;
    int lat, bcnt;
    repeat (3) @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL s1_latency: got %0d expected 33", lat); end
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s1_quot: got %h expected fffffffd", bus.quotient); end
    checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s1_rem: got %h expected ffffffff", bus.remainder); end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    checks++; if (bus.quotient !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s2_quot: got %h expected fffffffd", bus.quotient); end
    checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL s2_rem: got %h expected 00000001", bus.remainder); end
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, bcnt);
    checks++; if (bus.quotient !== 32'd3) begin errors++; $display("FAIL s3_quot: got %h expected 00000003", bus.quotient); end
    checks++; if (bus.remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s3_rem: got %h expected ffffffff", bus.remainder); end
    // Same bit pattern as s1 but unsigned: 4294967289 / 2
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    checks++; if (bus.quotient !== 32'h7FFF_FFFC) begin errors++; $display("FAIL s4_quot: got %h expected 7ffffffc", bus.quotient); end
    checks++; if (bus.remainder !== 32'd1) begin errors++; $display("FAIL s4_rem: got %h expected 00000001", bus.remainder); end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    repeat (3) @(negedge clk);
    run_op(1'b0, 32'd5, 32'd0, lat, bcnt);
    checks++; if (lat != 1) begin errors++; $display("FAIL z_latency: got %0d expected 1", lat); end
    checks++; if (bcnt != 1) begin errors++; $display("FAIL z_busy_cycles: got %0d expected 1", bcnt); end
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL z_quot: got %h expected ffffffff", bus.quotient); end
    checks++; if (bus.remainder !== 32'd5) begin errors++; $display("FAIL z_rem: got %h expected 00000005", bus.remainder); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL z_dz: got %b expected 1", bus.div_zero); end
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zs_quot: got %h expected ffffffff", bus.quotient); end
    checks++; if (bus.remainder !== 32'hFFFF_FFFB) begin errors++; $display("FAIL zs_rem: got %h expected fffffffb", bus.remainder); end
    run_op(1'b0, 32'd9, 32'd3, lat, bcnt);
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL z_clear_dz: got %b expected 0", bus.div_zero); end
    checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin
      errors++; $display("FAIL z_after_quot_rem: got %h/%h expected 00000003/00000000", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt;
    repeat (3) @(negedge clk);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    checks++; if (bus.quotient !== 32'h8000_0000) begin errors++; $display("FAIL ovf_quot: got %h expected 80000000", bus.quotient); end
    checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL ovf_rem: got %h expected 00000000", bus.remainder); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL ovf_dz: got %b expected 0", bus.div_zero); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL big_quot: got %h expected ffffffff", bus.quotient); end
    checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL big_rem: got %h expected 00000000", bus.remainder); end
  endtask

  task automatic test_start_while_busy;
    int lat, d0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 9) begin bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5; end
      if (lat == 10) bus.start = 1'b0;
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
    checks++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++; $display("FAIL busy_start_result: got %h/%h expected 0000000e/00000002", bus.quotient, bus.remainder);
    end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, d0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
    checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL b2b_first_quot: got %h expected 0000000e", bus.quotient); end
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 32) begin
        checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL b2b_hold_quot: got %h expected 0000000e", bus.quotient); end
      end
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin
      errors++; $display("FAIL b2b_result: got %h/%h expected 00000003/00000000", bus.quotient, bus.remainder);
    end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_dones: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_async_reset;
    int lat, bcnt, d0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
      errors++; $display("FAIL arst_outputs: got %h/%h expected 00000000/00000000", bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", done_cnt - d0); end
    run_op(1'b0, 32'd1000, 32'd10, lat, bcnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL arst_new_latency: got %0d expected 33", lat); end
    checks++; if (bus.quotient !== 32'd100 || bus.remainder !== 32'd0) begin
      errors++; $display("FAIL arst_new_result: got %h/%h expected 00000064/00000000", bus.quotient, bus.remainder);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring integer divider; the inverse-operation companion to the ALU/multiplier datapath.
- Takes dividend and divisor on a start pulse and iterates one quotient bit per clock.
- Returns quotient and remainder with a done pulse.
- Sits beside the ALU in the execute stage; the controller stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; sampled only when busy=0
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with accepted start
- divisor  input  WIDTH  denominator, sampled with accepted start
- busy  output  1  high while state is CALC or FIX
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_zero  output  1  registered; set when the last accepted op had divisor==0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, internal counter and registers cleared. An in-flight operation is discarded and produces no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1: latch operands, signed_op and sign flags (sign of dividend, sign of divisor; both forced to 0 when signed_op=0).
  - Convert operands to magnitudes.
  - If divisor==0, go to FIX with a zero flag. Otherwise go to CALC with count=0.
- CALC:
  - Each edge: partial remainder (WIDTH+1 bits) shifts left taking the next dividend MSB.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - After exactly WIDTH iterations, go to FIX.
- FIX (one edge):
  - Quotient negated if the sign flags differ; remainder negated if the dividend sign is set.
  - Load quotient/remainder/div_zero, pulse done=1 for one cycle, return to IDLE.
- Latency:
  - Start accepted at edge E0 → done high during the cycle after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
  - Divide-by-zero: done high after edge E0+1.
- Divide-by-zero: quotient = all ones, remainder = original dividend (unmodified), div_zero=1. Same result for signed and unsigned.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, div_zero=0. No trap.
- Truncation toward zero; remainder carries the dividend's sign; |remainder| < |divisor|.
- start while busy=1: ignored; operands not re-latched.
- start in the same cycle done is high (state IDLE): accepted normally. Outputs keep the previous result until the new FIX edge.
- quotient/remainder/div_zero hold their values between operations. They change only at a FIX edge or on reset.
- done never asserts without a preceding accepted start.

Test Plan:
- Unsigned: WIDTH=32, signed_op=0, 100/7 → done 33 cycles after the start edge, quotient=14, remainder=2, div_zero=0. busy high exactly 33 cycles.
- Signed: signed_op=1, -7/2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7/-2 → quotient=-3, remainder=1.
- Zero divisor: 5/0 → done one cycle after the start edge, quotient=0xFFFFFFFF, remainder=5, div_zero=1. A following 9/3 clears div_zero and gives quotient=3, remainder=0.
- Overflow and large unsigned: signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Start during busy: start 100/7, pulse start with 50/5 at cycle 10 → a single done at cycle 33 with 14/2. A back-to-back start in the done cycle is accepted and yields its own done 33 cycles later.
- Async reset: assert rst at cycle 15 of CALC (between edges) → outputs 0 immediately, no done afterwards. A new start after deassert gives the correct result.
